// File: rtl/encoder_rr.sv
// Registered round-robin priority encoder with valid/ready handshake on both sides.
// Define ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise the lowest set bit wins.
module encoder_rr #(
  parameter int OutputSize = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [(1<<OutputSize)-1:0] req_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [OutputSize-1:0]      data_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int N = 1 << OutputSize;

  logic [OutputSize-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [OutputSize-1:0] grant_idx;
  logic                  accept;

  function automatic logic [OutputSize-1:0] lowest_set(input logic [N-1:0] v);
    logic [OutputSize-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = i[OutputSize-1:0];
    end
    return idx;
  endfunction

  // The slot is free when empty or when the held grant leaves on this edge.
  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [OutputSize-1:0] ptr_q, ptr_d;
  logic [N-1:0]          masked_req;

  // Bits at or above ptr win first; if none are set, wrap to the unmasked vector.
  always_comb begin
    masked_req = req_i & ({N{1'b1}} << ptr_q);
    if (masked_req != '0) grant_idx = lowest_set(masked_req);
    else                  grant_idx = lowest_set(req_i);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && req_i != '0) ptr_d = grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb grant_idx = lowest_set(req_i);
`endif

  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    if (accept) begin
      if (req_i != '0) begin
        data_d  = grant_idx;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule
